branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32I pipeline. It replaces the static predict-not-taken policy in the IF stage.
- It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each cycle it gives the fetch stage a taken/not-taken prediction and a next-PC for the current fetch address.
- It takes resolved branch outcomes from EX. From these it updates its tables, flags mispredicts and supplies the redirect PC used to flush IF/ID.

Parameters:
- PC_WIDTH, 32, PC and target width.
- INDEX_WIDTH, 4, log2 of BTB entries (16). The tag width is derived internally as PC_WIDTH-INDEX_WIDTH-2.
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- IF_PC  input  PC_WIDTH  current fetch PC.
- pred_taken  output  1  prediction for IF_PC, combinational.
- pred_target  output  PC_WIDTH  predicted next PC for IF_PC, combinational.
- EX_valid  input  1  a valid, non-flushed instruction is in EX this cycle.
- EX_is_branch  input  1  the EX instruction is a conditional branch (opcode 1100011).
- EX_PC  input  PC_WIDTH  PC of the EX instruction.
- EX_taken  input  1  resolved branch outcome (BrEq/BrLT evaluated against funct3).
- EX_target  input  PC_WIDTH  resolved branch target (ALU result).
- EX_pred_taken  input  1  prediction carried down the pipe with this instruction.
- EX_pred_target  input  PC_WIDTH  predicted next PC carried down the pipe.
- mispredict  output  1  combinational; drives IF_flush/ID_flush and the PC mux.
- redirect_PC  output  PC_WIDTH  correct next PC when mispredict=1.
- branch_count  output  STAT_WIDTH  resolved branches since reset.
- mispredict_count  output  STAT_WIDTH  mispredicts since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Storage: per entry, valid (1 bit), tag, target (PC_WIDTH bits) and ctr (2 bits).
  - index = PC[INDEX_WIDTH+1:2].
  - tag = PC[PC_WIDTH-1:INDEX_WIDTH+2].
- Reset: asynchronous while rst_n=0.
  - All valid=0, all ctr=2'b01 and both statistics counters=0.
  - Outputs settle from the cleared state: pred_taken=0, pred_target=IF_PC+4.
  - Reset asserted mid-operation discards all learned state immediately.
- Lookup (0-cycle latency, combinational):
  - hit_if = valid[idx] & (tag[idx]==tag(IF_PC)).
  - pred_taken = hit_if & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : IF_PC+4.
- Resolution (combinational):
  - upd = EX_valid & EX_is_branch.
  - correct = EX_taken ? EX_target : EX_PC+4.
  - mispredict = upd & ((EX_taken != EX_pred_taken) | (EX_pred_target != correct)).
  - redirect_PC = correct, always driven.
  - When upd=0: mispredict=0.
- Update (rising edge when upd=1), using EX index and tag:
  - On EX hit:
    - Taken: ctr increments and saturates at 11; target <= EX_target.
    - Not taken: ctr decrements and saturates at 00; target unchanged.
  - On EX miss:
    - Taken: allocate (overwriting any aliased entry) with valid=1, tag, target=EX_target, ctr=2'b10.
    - Not taken: no change.
  - When upd=0, the tables are unchanged.
- Simultaneous lookup and update of the same index: the lookup returns pre-update contents. The update is visible on the following cycle. There is no write-through bypass.
- Statistics:
  - branch_count increments on each upd.
  - mispredict_count increments on each mispredict.
  - Both saturate at all-ones and do not wrap.
- Arithmetic: PC+4 is computed modulo 2^PC_WIDTH, so 0xFFFFFFFC+4 = 0x00000000.
- Branch-only scope: JAL/JALR are not tracked. Non-branch EX instructions never update the tables or counters.

Test Plan:
- Reset, then IF_PC=0x40 -> pred_taken=0, pred_target=0x44; branch_count=0.
- Resolve EX_PC=0x40, taken, EX_target=0x20, EX_pred_taken=0, EX_pred_target=0x44 -> same cycle: mispredict=1, redirect_PC=0x20. Next cycle, IF_PC=0x40 -> pred_taken=1, pred_target=0x20. Counts are 1/1.
- Continuing from the previous step, resolve 0x40 not-taken twice with pred_taken=1/target 0x20, then 0 -> ctr goes 10→01→00. First resolution: mispredict=1, redirect_PC=0x44. Lookup gives pred_taken=0, pred_target=0x44. A third not-taken keeps ctr at 00, and with pred_taken=0/target 0x44 gives mispredict=0.
- Alias test: with 0x40 allocated, IF_PC=0x80 (same index 0, different tag) -> pred_taken=0, pred_target=0x84. Then resolve 0x80 taken to 0x100 -> lookup of 0x40 now misses.
- Same-cycle read/write: IF_PC=0x40 while EX updates index 0 from empty -> that cycle pred_taken=0; the next cycle pred_taken=1. Then assert rst_n=0 mid-stream -> pred_taken drops to 0 without a clock edge, and the counters read 0.
- Drive 70000 upd cycles, all mispredicting -> both counters hold 0xFFFF. Separately, EX_valid=1 with EX_is_branch=0 -> no counter or table change, and mispredict=0.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch/EX/statistics signals between the pipeline and the branch target predictor.
// The pipeline is the master and the predictor is the slave.
interface branch_target_predictor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   IF_PC;
    logic                  pred_taken;
    logic [PC_WIDTH-1:0]   pred_target;
    logic                  EX_valid;
    logic                  EX_is_branch;
    logic [PC_WIDTH-1:0]   EX_PC;
    logic                  EX_taken;
    logic [PC_WIDTH-1:0]   EX_target;
    logic                  EX_pred_taken;
    logic [PC_WIDTH-1:0]   EX_pred_target;
    logic                  mispredict;
    logic [PC_WIDTH-1:0]   redirect_PC;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output IF_PC, EX_valid, EX_is_branch, EX_PC, EX_taken, EX_target,
               EX_pred_taken, EX_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_PC,
               branch_count, mispredict_count
    );

    modport slave (
        input  IF_PC, EX_valid, EX_is_branch, EX_PC, EX_taken, EX_target,
               EX_pred_taken, EX_pred_target,
        output pred_taken, pred_target, mispredict, redirect_PC,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// combinational EX mispredict/redirect, table and statistics update on the clock edge.
module branch_target_predictor #(
    parameter int PC_WIDTH    = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int STAT_WIDTH  = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_target_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = PC_WIDTH - INDEX_WIDTH - 2;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [ENTRIES-1:0]                r_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]     r_tag;
    logic [ENTRIES-1:0][PC_WIDTH-1:0]  r_target;
    logic [ENTRIES-1:0][1:0]           r_ctr;
    logic [STAT_WIDTH-1:0]             r_branch_cnt;
    logic [STAT_WIDTH-1:0]             r_mispred_cnt;

    logic [INDEX_WIDTH-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0]       w_if_tag, w_ex_tag;
    logic                   w_if_hit, w_ex_hit;
    logic                   w_pred_taken;
    logic                   w_upd;
    logic                   w_mispredict;
    logic [PC_WIDTH-1:0]    w_correct;

    assign w_if_idx = bus.IF_PC[INDEX_WIDTH+1:2];
    assign w_if_tag = bus.IF_PC[PC_WIDTH-1:INDEX_WIDTH+2];
    assign w_ex_idx = bus.EX_PC[INDEX_WIDTH+1:2];
    assign w_ex_tag = bus.EX_PC[PC_WIDTH-1:INDEX_WIDTH+2];

    // Lookup reads the registered table only, so a same-index update shows next cycle.
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_taken ? r_target[w_if_idx] : bus.IF_PC + PC_STEP;

    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd        = bus.EX_valid && bus.EX_is_branch;
    assign w_correct    = bus.EX_taken ? bus.EX_target : bus.EX_PC + PC_STEP;
    assign w_mispredict = w_upd && ((bus.EX_taken != bus.EX_pred_taken) ||
                                    (bus.EX_pred_target != w_correct));

    assign bus.mispredict       = w_mispredict;
    assign bus.redirect_PC      = w_correct;
    assign bus.branch_count     = r_branch_cnt;
    assign bus.mispredict_count = r_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                if (bus.EX_taken) begin
                    if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    r_target[w_ex_idx] <= bus.EX_target;
                end else if (r_ctr[w_ex_idx] != 2'b00) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (bus.EX_taken) begin
                // Taken miss evicts whatever alias occupied the slot.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= bus.EX_target;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_upd && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + STAT_WIDTH'(1);
            if (w_mispredict && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + STAT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a table-level reference model is
// compared against the outputs every cycle, plus hand-computed literal checks.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cmp_en   = 1'b0;

    branch_target_predictor_if #(.PC_WIDTH(32), .STAT_WIDTH(16)) bus ();

    branch_target_predictor #(.PC_WIDTH(32), .INDEX_WIDTH(4), .STAT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: 16 slots keyed by word address mod 16, tag = PC / 64.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_bc, m_mc;

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tagof(logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
    endfunction

    function automatic bit exp_pred_taken();
        return m_hit(bus.IF_PC) && (m_ctr[slot(bus.IF_PC)] >= 2);
    endfunction

    function automatic logic [31:0] exp_pred_target();
        return exp_pred_taken() ? m_tgt[slot(bus.IF_PC)] : bus.IF_PC + 32'd4;
    endfunction

    function automatic logic [31:0] exp_correct();
        return bus.EX_taken ? bus.EX_target : bus.EX_PC + 32'd4;
    endfunction

    function automatic bit exp_mispredict();
        return bus.EX_valid && bus.EX_is_branch &&
               ((bus.EX_taken != bus.EX_pred_taken) || (bus.EX_pred_target != exp_correct()));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
                m_tag[i]   = '0;
                m_tgt[i]   = '0;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (bus.EX_valid && bus.EX_is_branch) begin
            if (exp_mispredict()) m_mc = (m_mc < 65535) ? m_mc + 1 : m_mc;
            m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
            if (m_hit(bus.EX_PC)) begin
                if (bus.EX_taken) begin
                    m_ctr[slot(bus.EX_PC)] = (m_ctr[slot(bus.EX_PC)] < 3) ? m_ctr[slot(bus.EX_PC)] + 1 : 3;
                    m_tgt[slot(bus.EX_PC)] = bus.EX_target;
                end else begin
                    m_ctr[slot(bus.EX_PC)] = (m_ctr[slot(bus.EX_PC)] > 0) ? m_ctr[slot(bus.EX_PC)] - 1 : 0;
                end
            end else if (bus.EX_taken) begin
                m_valid[slot(bus.EX_PC)] = 1'b1;
                m_tag[slot(bus.EX_PC)]   = tagof(bus.EX_PC);
                m_tgt[slot(bus.EX_PC)]   = bus.EX_target;
                m_ctr[slot(bus.EX_PC)]   = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m.pred_taken",  64'(bus.pred_taken),       64'(exp_pred_taken()));
            chk("m.pred_target", 64'(bus.pred_target),      64'(exp_pred_target()));
            chk("m.mispredict",  64'(bus.mispredict),       64'(exp_mispredict()));
            chk("m.redirect_PC", 64'(bus.redirect_PC),      64'(exp_correct()));
            chk("m.branch_cnt",  64'(bus.branch_count),     64'(m_bc));
            chk("m.mispred_cnt", 64'(bus.mispredict_count), 64'(m_mc));
        end
    end

    task automatic ex_idle();
        bus.EX_valid = 1'b0; bus.EX_is_branch = 1'b0; bus.EX_PC = '0; bus.EX_taken = 1'b0;
        bus.EX_target = '0; bus.EX_pred_taken = 1'b0; bus.EX_pred_target = '0;
    endtask

    task automatic ex_br(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
        bus.EX_valid = 1'b1; bus.EX_is_branch = 1'b1; bus.EX_PC = pc; bus.EX_taken = tk;
        bus.EX_target = tgt; bus.EX_pred_taken = ptk; bus.EX_pred_target = ptgt;
    endtask

    // Inputs change just after the rising edge; checks land on the falling edge.
    task automatic next();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.IF_PC = 32'h40;
        ex_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst.pred_taken",  64'(bus.pred_taken), 64'd0);
        chk("rst.pred_target", 64'(bus.pred_target), 64'h44);
        chk("rst.branch_cnt",  64'(bus.branch_count), 64'd0);
        chk("rst.mispredict",  64'(bus.mispredict), 64'd0);

        // First taken resolution allocates; lookup in the same cycle sees the old table.
        next(); ex_br(32'h40, 1, 32'h20, 0, 32'h44);
        @(negedge clk);
        chk("alloc.mispredict", 64'(bus.mispredict), 64'd1);
        chk("alloc.redirect",   64'(bus.redirect_PC), 64'h20);
        chk("same_cyc.pred",    64'(bus.pred_taken), 64'd0);
        next(); ex_idle();
        @(negedge clk);
        chk("alloc.pred_taken",  64'(bus.pred_taken), 64'd1);
        chk("alloc.pred_target", 64'(bus.pred_target), 64'h20);
        chk("alloc.bc", 64'(bus.branch_count), 64'd1);
        chk("alloc.mc", 64'(bus.mispredict_count), 64'd1);

        // Train down: 10 -> 01 -> 00, then saturate at 00.
        next(); ex_br(32'h40, 0, 32'h20, 1, 32'h20);
        @(negedge clk);
        chk("nt1.mispredict", 64'(bus.mispredict), 64'd1);
        chk("nt1.redirect",   64'(bus.redirect_PC), 64'h44);
        next(); ex_br(32'h40, 0, 32'h20, 0, 32'h44);
        @(negedge clk);
        chk("nt2.mispredict", 64'(bus.mispredict), 64'd0);
        next(); ex_idle();
        @(negedge clk);
        chk("nt.pred_taken",  64'(bus.pred_taken), 64'd0);
        chk("nt.pred_target", 64'(bus.pred_target), 64'h44);
        next(); ex_br(32'h40, 0, 32'h20, 0, 32'h44);
        @(negedge clk);
        chk("nt3.mispredict", 64'(bus.mispredict), 64'd0);
        next(); ex_idle();
        @(negedge clk);
        chk("nt.bc", 64'(bus.branch_count), 64'd4);
        chk("nt.mc", 64'(bus.mispredict_count), 64'd2);

        // Retrain 0x40 to taken (00 -> 01 -> 10), then alias it out with 0x80.
        next(); ex_br(32'h40, 1, 32'h20, 0, 32'h44);
        next(); ex_br(32'h40, 1, 32'h20, 0, 32'h44);
        next(); ex_idle();
        @(negedge clk);
        chk("retrain.pred", 64'(bus.pred_taken), 64'd1);
        next(); bus.IF_PC = 32'h80;
        @(negedge clk);
        chk("alias.pred_taken",  64'(bus.pred_taken), 64'd0);
        chk("alias.pred_target", 64'(bus.pred_target), 64'h84);
        next(); ex_br(32'h80, 1, 32'h100, 0, 32'h84);
        next(); ex_idle(); bus.IF_PC = 32'h40;
        @(negedge clk);
        chk("alias.old_miss", 64'(bus.pred_taken), 64'd0);
        chk("alias.old_tgt",  64'(bus.pred_target), 64'h44);
        next(); bus.IF_PC = 32'h80;
        @(negedge clk);
        chk("alias.new_hit", 64'(bus.pred_taken), 64'd1);
        chk("alias.new_tgt", 64'(bus.pred_target), 64'h100);

        // Reset without a clock edge clears learned state immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.pred", 64'(bus.pred_taken), 64'd0);
        chk("async_rst.bc",   64'(bus.branch_count), 64'd0);
        chk("async_rst.mc",   64'(bus.mispredict_count), 64'd0);
        next(); rst_n = 1'b1;

        // PC+4 wraps modulo 2^32.
        bus.IF_PC = 32'hFFFF_FFFC;
        ex_br(32'hFFFF_FFFC, 0, 32'h10, 0, 32'h0);
        @(negedge clk);
        chk("wrap.pred_target", 64'(bus.pred_target), 64'h0);
        chk("wrap.redirect",    64'(bus.redirect_PC), 64'h0);
        chk("wrap.mispredict",  64'(bus.mispredict), 64'd0);

        // Non-branch in EX must not touch tables or counters.
        next(); ex_br(32'h44, 1, 32'h200, 0, 32'h48); bus.EX_is_branch = 1'b0; bus.IF_PC = 32'h44;
        @(negedge clk);
        chk("nonbr.mispredict", 64'(bus.mispredict), 64'd0);
        next(); ex_idle();
        @(negedge clk);
        chk("nonbr.pred", 64'(bus.pred_taken), 64'd0);
        chk("nonbr.bc",   64'(bus.branch_count), 64'd1);
        chk("nonbr.mc",   64'(bus.mispredict_count), 64'd0);

        // Saturation: 70000 always-mispredicting branches.
        next(); ex_br(32'h200, 1, 32'h300, 0, 32'h204);
        repeat (70000) @(posedge clk);
        #1 ex_idle();
        @(negedge clk);
        chk("sat.bc", 64'(bus.branch_count), 64'hFFFF);
        chk("sat.mc", 64'(bus.mispredict_count), 64'hFFFF);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
